// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data memory block.
// Error bit indices, default sizing and the access-check helper used by data_mem.
package dmem_pkg;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  localparam int          DMEM_DEPTH_DEF     = 256;
  localparam logic [31:0] DMEM_MMIO_ADDR_DEF = 32'hFFFF_FFFC;

  // Error flags raised by one cycle's access; nothing is flagged when idle.
  function automatic logic [1:0] access_err(input logic en, input logic aligned,
                                            input logic range_ok);
    logic [1:0] e;
    e               = 2'b00;
    e[ERR_MISALIGN] = en & ~aligned;
    e[ERR_RANGE]    = en & ~range_ok;
    return e;
  endfunction

endpackage

// File: rtl/data_mem_sat_counter.sv
// Saturating up-counter used for the data memory access statistics.
// Holds at all-ones once reached; cleared asynchronously by rst.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with combinational read, synchronous write,
// sticky access-error flags and saturating access counters. Optional MMIO
// output register at MMIO_ADDR is compiled in with DMEM_MMIO_EN.
module data_mem
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = DMEM_DEPTH_DEF,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter int          CNT_W     = 16,
  parameter logic [31:0] MMIO_ADDR = DMEM_MMIO_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             memRead_en,
  input  logic             memWrite_en,
  output logic [31:0]      memOut,
  output logic [1:0]       err,
`ifdef DMEM_MMIO_EN
  output logic [31:0]      out_port,
`endif
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

`ifdef DMEM_MMIO_EN
  localparam logic MMIO_ON = 1'b1;
`else
  localparam logic MMIO_ON = 1'b0;
`endif

  logic [31:0]       mem [DEPTH];
  logic              aligned;
  logic              in_range;
  logic              mmio_hit;
  logic              range_ok;
  logic              valid;
  logic              any_en;
  logic              rd_ok;
  logic              wr_ok;
  logic [ADDR_W-1:0] index;

  // Decode: MMIO only counts as in-range when the feature is built in.
  always_comb begin
    aligned  = (addr[1:0] == 2'b00);
    in_range = ({2'b00, addr[31:2]} < 32'(DEPTH));
    mmio_hit = MMIO_ON & (addr == MMIO_ADDR);
    range_ok = in_range | mmio_hit;
    valid    = aligned & range_ok;
    any_en   = memRead_en | memWrite_en;
    rd_ok    = memRead_en & valid;
    wr_ok    = memWrite_en & valid;
    index    = addr[ADDR_W+1:2];
  end

  // Read-before-write falls out naturally: the array updates only on the edge.
  always_comb begin
    memOut = '0;
    if (rd_ok) begin
`ifdef DMEM_MMIO_EN
      memOut = mmio_hit ? out_port : mem[index];
`else
      memOut = mem[index];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok && !mmio_hit) begin
      mem[index] <= wdata;
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port <= '0;
    end else if (wr_ok && mmio_hit) begin
      out_port <= wdata;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 2'b00;
    end else begin
      err <= err | access_err(any_en, aligned, range_ok);
    end
  end

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_ok),
    .count (rd_count)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_ok),
    .count (wr_count)
  );

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem (4-bit counters, DEPTH=256) against a
// word-array reference model; MMIO checks follow DMEM_MMIO_EN.
module tb_data_mem;

  localparam int          DEPTH = 256;
  localparam int          CNT_W = 4;
  localparam int          CMAX  = 15;
  localparam logic [31:0] MMIO  = 32'hFFFF_FFFC;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      addr = '0;
  logic [31:0]      wdata = '0;
  logic             memRead_en = 1'b0;
  logic             memWrite_en = 1'b0;
  logic [31:0]      memOut;
  logic [1:0]       err;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
`ifdef DMEM_MMIO_EN
  logic [31:0]      out_port;
`endif

  int compared   = 0;
  int mismatched = 0;

  data_mem #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .memRead_en  (memRead_en),
    .memWrite_en (memWrite_en),
    .memOut      (memOut),
    .err         (err),
`ifdef DMEM_MMIO_EN
    .out_port    (out_port),
`endif
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array plus flags and counts.
  logic [31:0] m_mem [DEPTH];
  logic [1:0]  m_err;
  int          m_rd;
  int          m_wr;
  logic [31:0] m_out;

  function automatic bit m_is_mmio(input logic [31:0] a);
    return MMIO_ON && (a == MMIO);
  endfunction

  function automatic bit m_valid(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4 < DEPTH) || m_is_mmio(a));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic r);
    if (!r || !m_valid(a)) return 32'h0;
    if (m_is_mmio(a)) return m_out;
    return m_mem[a / 4];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_err = 2'b00;
    m_rd  = 0;
    m_wr  = 0;
    m_out = 32'h0;
  endtask

  task automatic m_clock(input logic [31:0] a, input logic [31:0] w,
                         input logic r, input logic wn);
    bit ok;
    ok = m_valid(a);
    if (r || wn) begin
      if (a % 4 != 0) m_err[0] = 1'b1;
      if (!((a / 4 < DEPTH) || m_is_mmio(a))) m_err[1] = 1'b1;
    end
    if (r && ok && m_rd < CMAX) m_rd++;
    if (wn && ok && m_wr < CMAX) m_wr++;
    if (wn && ok) begin
      if (m_is_mmio(a)) m_out = w;
      else m_mem[a / 4] = w;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] w,
                       input logic r, input logic wn);
    @(negedge clk);
    addr = a; wdata = w; memRead_en = r; memWrite_en = wn;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    m_clock(addr, wdata, memRead_en, memWrite_en);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; memRead_en = 1'b0; memWrite_en = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    memRead_en = 1'b1; addr = 32'h10;
    #1;
    m_reset();
    compared++;
    if (memOut !== 32'h0 || err !== 2'b00 || rd_count !== 4'h0 || wr_count !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_state: memOut=%h err=%b rd=%0d wr=%0d, want all 0",
               memOut, err, rd_count, wr_count);
    end
`ifdef DMEM_MMIO_EN
    compared++;
    if (out_port !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_out_port: got %h want 0", out_port);
    end
`endif
    @(negedge clk);
    rst = 1'b0; memRead_en = 1'b0;
    drive(32'h10, 32'h0, 1'b1, 1'b0);
    compared++;
    if (memOut !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_load: memOut=%h want 0", memOut);
    end
    step();
    compared++;
    if (err !== 2'b00 || rd_count !== 4'd1) begin
      mismatched++;
      $display("FAIL reset_load_count: err=%b rd=%0d want err=00 rd=1", err, rd_count);
    end
  endtask

  task automatic test_store_rbw();
    drive(32'h20, 32'hDEAD_BEEF, 1'b1, 1'b1);
    compared++;
    if (memOut !== 32'h0) begin
      mismatched++;
      $display("FAIL rbw_old_data: memOut=%h want 0", memOut);
    end
    step();
    compared++;
    if (wr_count !== 4'd1) begin
      mismatched++;
      $display("FAIL rbw_wr_count: got %0d want 1", wr_count);
    end
    drive(32'h20, 32'h0, 1'b1, 1'b0);
    compared++;
    if (memOut !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL rbw_new_data: memOut=%h want deadbeef", memOut);
    end
    step();
  endtask

  task automatic test_misaligned();
    drive(32'h22, 32'h1234_5678, 1'b0, 1'b1);
    step();
    compared++;
    if (err !== 2'b01 || wr_count !== 4'd1) begin
      mismatched++;
      $display("FAIL misalign_store: err=%b wr=%0d want err=01 wr=1", err, wr_count);
    end
    drive(32'h20, 32'h0, 1'b1, 1'b0);
    compared++;
    if (memOut !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL misalign_untouched: memOut=%h want deadbeef", memOut);
    end
    step();
    drive(32'h24, 32'h0, 1'b1, 1'b0);
    step();
    compared++;
    if (err !== 2'b01) begin
      mismatched++;
      $display("FAIL misalign_sticky: err=%b want 01", err);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] wr_before;
    drive(32'h400, 32'h0, 1'b1, 1'b0);
    compared++;
    if (memOut !== 32'h0) begin
      mismatched++;
      $display("FAIL range_load: memOut=%h want 0", memOut);
    end
    step();
    compared++;
    if (err !== 2'b11) begin
      mismatched++;
      $display("FAIL range_err: err=%b want 11", err);
    end
    wr_before = wr_count;
    drive(32'h400, 32'hCAFE_F00D, 1'b0, 1'b1);
    step();
    compared++;
    if (wr_count !== wr_before) begin
      mismatched++;
      $display("FAIL range_store_count: wr=%0d want %0d", wr_count, wr_before);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'(i) * 4, 32'h0, 1'b1, 1'b0);
      compared++;
      if (memOut !== ((i == 8) ? 32'hDEAD_BEEF : 32'h0)) begin
        mismatched++;
        $display("FAIL range_sweep[%0d]: memOut=%h", i, memOut);
      end
      step();
    end
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(32'($urandom_range(0, DEPTH - 1)) * 4, 32'h0, 1'b1, 1'b0);
      step();
      want = (i + 1 > CMAX) ? CMAX : i + 1;
      compared++;
      if (rd_count !== CNT_W'(want)) begin
        mismatched++;
        $display("FAIL saturate[%0d]: rd=%0d want %0d", i, rd_count, want);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(32'h8, 32'h0000_55AA, 1'b0, 1'b1);
    step();
    drive(32'h9, 32'h0, 1'b1, 1'b0);
    step();
    drive(32'h8, 32'h7777_7777, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    m_reset();
    compared++;
    if (memOut !== 32'h0 || err !== 2'b00 || rd_count !== 4'h0 || wr_count !== 4'h0) begin
      mismatched++;
      $display("FAIL async_reset: memOut=%h err=%b rd=%0d wr=%0d, want all 0",
               memOut, err, rd_count, wr_count);
    end
    @(negedge clk);
    rst = 1'b0; memRead_en = 1'b0; memWrite_en = 1'b0;
    drive(32'h8, 32'h0, 1'b1, 1'b0);
    compared++;
    if (memOut !== 32'h0) begin
      mismatched++;
      $display("FAIL async_abort: memOut=%h want 0", memOut);
    end
    step();
  endtask

  task automatic test_mmio();
    do_reset();
    drive(MMIO, 32'h0000_00A5, 1'b0, 1'b1);
    step();
    drive(MMIO, 32'h0, 1'b1, 1'b0);
`ifdef DMEM_MMIO_EN
    compared++;
    if (out_port !== 32'hA5 || err !== 2'b00 || memOut !== 32'hA5 || wr_count !== 4'd1) begin
      mismatched++;
      $display("FAIL mmio_on: out_port=%h err=%b memOut=%h wr=%0d want a5/00/a5/1",
               out_port, err, memOut, wr_count);
    end
`else
    compared++;
    if (err !== 2'b10 || memOut !== 32'h0 || wr_count !== 4'd0) begin
      mismatched++;
      $display("FAIL mmio_off: err=%b memOut=%h wr=%0d want 10/0/0", err, memOut, wr_count);
    end
`endif
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] w;
    logic        r;
    logic        wn;
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: a = 32'($urandom_range(0, 15)) * 4;
          4, 5:       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
          6:          a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
          7:          a = 32'h400 | $urandom;
          8:          a = MMIO;
          default:    a = $urandom;
        endcase
        w  = $urandom;
        r  = 1'($urandom_range(0, 1));
        wn = 1'($urandom_range(0, 1));
        drive(a, w, r, wn);
        compared++;
        if (memOut !== m_load(a, r)) begin
          mismatched++;
          $display("FAIL rand_load a=%h: memOut=%h want %h", a, memOut, m_load(a, r));
        end
        step();
        compared++;
        if (err !== m_err || rd_count !== CNT_W'(m_rd) || wr_count !== CNT_W'(m_wr)) begin
          mismatched++;
          $display("FAIL rand_state a=%h: err=%b rd=%0d wr=%0d want %b %0d %0d",
                   a, err, rd_count, wr_count, m_err, m_rd, m_wr);
        end
`ifdef DMEM_MMIO_EN
        compared++;
        if (out_port !== m_out) begin
          mismatched++;
          $display("FAIL rand_out_port: got %h want %h", out_port, m_out);
        end
`endif
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_rbw();
    test_misaligned();
    test_out_of_range();
    test_saturate();
    test_async_reset();
    test_mmio();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
